// File: rtl/ir_fetch_sequencer.sv
// Instruction-fetch sequencer feeding the IR: reads two bytes per instruction
// (low byte first), steers the IR controls, hands the result to the decoder
// and owns the program counter.
module ir_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  input  logic              mem_ready_i,
  input  logic [7:0]        mem_data_i,
  output logic              ir_e_o,
  output logic [1:0]        ir_funsel_o,
  output logic              ir_lh_o,
  output logic [7:0]        ir_input_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              decode_ready_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_load_value_i,
  output logic              fault_o
);

  localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [1:0]        FS_CLEAR  = 2'b00;
  localparam logic [1:0]        FS_LOAD   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_FETCH_LO = 3'd2,
    S_FETCH_HI = 3'd3,
    S_DISPATCH = 3'd4,
    S_FAULT    = 3'd5
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   inst_addr_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                in_fetch;

  assign in_fetch = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);

  // State, PC, instruction address and wait-counter sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_addr_q <= '0;
      wait_q      <= '0;
    end else if (pc_load_i && (state_q != S_FAULT)) begin
      // Redirect wins over everything; a DISPATCH handshake this cycle still counts.
      pc_q   <= pc_load_value_i;
      wait_q <= '0;
      if (state_q != S_IDLE) begin
        state_q <= run_i ? S_CLR : S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_q <= S_CLR;
            wait_q  <= '0;
          end
        end
        S_CLR: begin
          state_q <= S_FETCH_LO;
          wait_q  <= '0;
        end
        S_FETCH_LO, S_FETCH_HI: begin
          if (mem_ready_i) begin
            pc_q   <= pc_q + ADDR_W'(1);
            wait_q <= '0;
            if (state_q == S_FETCH_LO) begin
              inst_addr_q <= pc_q;
              state_q     <= S_FETCH_HI;
            end else begin
              state_q <= S_DISPATCH;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_FAULT;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DISPATCH: begin
          if (decode_ready_i) begin
            state_q <= run_i ? S_FETCH_LO : S_IDLE;
            wait_q  <= '0;
          end
        end
        S_FAULT: begin
          if (!run_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state; IR load strobes follow MemReady.
  always_comb begin
    mem_read_o   = 1'b0;
    ir_e_o       = 1'b0;
    ir_funsel_o  = FS_CLEAR;
    ir_lh_o      = 1'b0;
    inst_valid_o = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      S_CLR: begin
        ir_e_o      = 1'b1;
        ir_funsel_o = FS_CLEAR;
      end
      S_FETCH_LO, S_FETCH_HI: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_e_o      = 1'b1;
          ir_funsel_o = FS_LOAD;
          ir_lh_o     = (state_q == S_FETCH_HI);
        end
      end
      S_DISPATCH: inst_valid_o = 1'b1;
      S_FAULT:    fault_o      = 1'b1;
      default:    ;
    endcase
  end

  assign mem_address_o = pc_q;
  assign inst_addr_o   = inst_addr_q;
  assign ir_input_o    = mem_data_i;

  logic unused_fetch;
  assign unused_fetch = in_fetch;

endmodule
